// File: rtl/cwalk_pkg.sv
// Shared definitions for the crosswalk controller.
//   state_e : crosswalk FSM state encoding (3 bits)
//   TIMER_W : width of the per-state tick down-counter
package cwalk_pkg;

    localparam int TIMER_W = 4;

    typedef enum logic [2:0] {
        GREEN   = 3'd0,
        YELLOW  = 3'd1,
        ALLRED1 = 3'd2,
        WALK    = 3'd3,
        FLASH   = 3'd4,
        ALLRED2 = 3'd5
    } state_e;

endpackage

// File: rtl/cwalk_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clock cycles.
// Ports:
//   clk  : system clock, rising edge
//   clr  : synchronous active-high clear, forces the count to 0
//   tick : high for the one cycle in which the count equals TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // NOTE: registers are written with <= so every flop in the design samples
    // pre-edge values, regardless of the order the always_ff blocks run in.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cwalk_ctrl.sv
// Crosswalk sequencing FSM fed by the pedestrian request latch.
// Ports:
//   clk         : system clock, rising edge
//   clr         : synchronous active-high reset, highest priority
//   walk_req    : latched pedestrian request (q of the upstream latch)
//   req_clr     : clear strobe back to the request latch
//   car_green   : car green lamp
//   car_yellow  : car yellow lamp
//   car_red     : car red lamp
//   walk_on     : pedestrian WALK lamp
//   dontwalk_on : pedestrian DON'T-WALK lamp
//   count_out   : remaining pedestrian ticks (0 outside WALK/FLASH)
module cwalk_ctrl
    import cwalk_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int GREEN_MIN = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 8,
    parameter int FLASH_T   = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               walk_req,
    output logic               req_clr,
    output logic               car_green,
    output logic               car_yellow,
    output logic               car_red,
    output logic               walk_on,
    output logic               dontwalk_on,
    output logic [TIMER_W-1:0] count_out
);

    // Timer load values: a state lasting DUR ticks counts DUR-1 down to 0.
    localparam logic [TIMER_W-1:0] GREEN_LD  = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LD = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LD = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] WALK_LD   = TIMER_W'(WALK_T - 1);
    localparam logic [TIMER_W-1:0] FLASH_LD  = TIMER_W'(FLASH_T - 1);

    logic               tick;
    state_e             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               flash_q;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= GREEN;
            timer_q <= GREEN_LD;
            flash_q <= 1'b0;
        end else if (tick) begin
            if (timer_q != '0) begin
                timer_q <= timer_q - TIMER_W'(1);
                if (state_q == FLASH) begin
                    flash_q <= ~flash_q;
                end
            end else begin
                unique case (state_q)
                    // Timer stays at 0 while idle, so a request is taken on
                    // the very next tick after it appears.
                    GREEN: begin
                        if (walk_req) begin
                            state_q <= YELLOW;
                            timer_q <= YELLOW_LD;
                        end
                    end
                    YELLOW: begin
                        state_q <= ALLRED1;
                        timer_q <= ALLRED_LD;
                    end
                    ALLRED1: begin
                        state_q <= WALK;
                        timer_q <= WALK_LD;
                    end
                    WALK: begin
                        state_q <= FLASH;
                        timer_q <= FLASH_LD;
                        flash_q <= 1'b1;
                    end
                    FLASH: begin
                        state_q <= ALLRED2;
                        timer_q <= ALLRED_LD;
                    end
                    ALLRED2: begin
                        state_q <= GREEN;
                        timer_q <= GREEN_LD;
                    end
                    default: begin
                        state_q <= GREEN;
                        timer_q <= GREEN_LD;
                    end
                endcase
            end
        end
    end

    // Moore decode straight from the state register, so lamps follow the
    // state in the same cycle it changes.
    assign car_green   = (state_q == GREEN);
    assign car_yellow  = (state_q == YELLOW);
    assign car_red     = (state_q == ALLRED1) || (state_q == WALK) ||
                         (state_q == FLASH)   || (state_q == ALLRED2);
    assign walk_on     = (state_q == WALK);
    assign dontwalk_on = (state_q == FLASH) ? flash_q
                                            : (state_q != WALK);
    assign count_out   = ((state_q == WALK) || (state_q == FLASH))
                         ? timer_q + TIMER_W'(1) : '0;

    // Holding the latch clear through WALK discards presses made while the
    // pedestrians already have the crossing.
    assign req_clr     = clr || (state_q == WALK);

endmodule

// File: tb/tb_cwalk_ctrl.sv
// Self-checking bench for cwalk_ctrl with short timing parameters.
module tb_cwalk_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       walk_req;
    logic       req_clr;
    logic       car_green;
    logic       car_yellow;
    logic       car_red;
    logic       walk_on;
    logic       dontwalk_on;
    logic [3:0] count_out;

    // Upstream request latch model and the mux choosing direct or latched drive.
    logic use_latch = 1'b0;
    logic button    = 1'b0;
    logic walk_drv  = 1'b0;
    logic latch_q   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    cwalk_ctrl #(
        .TICK_DIV  (4),
        .GREEN_MIN (3),
        .YELLOW_T  (2),
        .ALLRED_T  (1),
        .WALK_T    (4),
        .FLASH_T   (3)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .walk_req    (walk_req),
        .req_clr     (req_clr),
        .car_green   (car_green),
        .car_yellow  (car_yellow),
        .car_red     (car_red),
        .walk_on     (walk_on),
        .dontwalk_on (dontwalk_on),
        .count_out   (count_out)
    );

    always #5 clk = ~clk;

    assign walk_req = use_latch ? latch_q : walk_drv;

    always @(posedge clk) begin
        if (req_clr) begin
            latch_q <= 1'b0;
        end else if (button) begin
            latch_q <= 1'b1;
        end
    end

    // Observed vector: {green, yellow, red, walk, dontwalk, req_clr, count}
    typedef logic [9:0] obs_t;

    localparam logic [4:0] LG  = 5'b10001;  // green + don't-walk
    localparam logic [4:0] LY  = 5'b01001;  // yellow + don't-walk
    localparam logic [4:0] LR  = 5'b00101;  // red + don't-walk
    localparam logic [4:0] LW  = 5'b00110;  // red + walk
    localparam logic [4:0] LF0 = 5'b00100;  // red, don't-walk dark

    typedef struct {
        int    cycles;
        logic  clr;
        logic  walk;
        obs_t  exp;
        string name;
    } vec_t;

    vec_t vecs[$];

    function automatic obs_t observe();
        return {car_green, car_yellow, car_red, walk_on, dontwalk_on,
                req_clr, count_out};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic cl, input logic w, input logic b);
        @(negedge clk);
        clr      = cl;
        walk_drv = w;
        button   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int c, input logic cl, input logic w,
                       input logic [4:0] lamp, input logic rc,
                       input int cnt, input string nm);
        vec_t v;
        v.cycles = c;
        v.clr    = cl;
        v.walk   = w;
        v.exp    = {lamp, rc, 4'(cnt)};
        v.name   = nm;
        vecs.push_back(v);
    endtask

    // Full pedestrian cycle from YELLOW entry back to idle GREEN. walk=1 on
    // the yellow row keeps the request high on the tick that leaves GREEN.
    task automatic add_ped_cycle(input string tag);
        add(8, 1'b0, 1'b1, LY, 1'b0, 0, {tag, "_yellow"});
        add(4, 1'b0, 1'b0, LR, 1'b0, 0, {tag, "_allred1"});
        for (int k = 4; k >= 1; k--) begin
            add(4, 1'b0, 1'b0, LW, 1'b1, k, {tag, "_walk"});
        end
        add(4, 1'b0, 1'b0, LR,  1'b0, 3, {tag, "_flash3"});
        add(4, 1'b0, 1'b0, LF0, 1'b0, 2, {tag, "_flash2"});
        add(4, 1'b0, 1'b0, LR,  1'b0, 1, {tag, "_flash1"});
        add(4, 1'b0, 1'b0, LR,  1'b0, 0, {tag, "_allred2"});
        add(12, 1'b0, 1'b0, LG, 1'b0, 0, {tag, "_green_idle"});
    endtask

    initial begin
        int n;
        clr      = 1'b1;
        walk_drv = 1'b0;
        button   = 1'b0;

        // Idle, a one-cycle glitch off the tick, then a late request.
        add(2,  1'b1, 1'b0, LG, 1'b1, 0, "reset");
        add(38, 1'b0, 1'b0, LG, 1'b0, 0, "idle");
        add(1,  1'b0, 1'b1, LG, 1'b0, 0, "glitch");
        add(3,  1'b0, 1'b0, LG, 1'b0, 0, "idle2");
        add(1,  1'b0, 1'b1, LG, 1'b0, 0, "late_req");
        add_ped_cycle("late");
        // Early request straight out of reset.
        add(2,  1'b1, 1'b1, LG, 1'b1, 0, "reset2");
        add(11, 1'b0, 1'b1, LG, 1'b0, 0, "early_green");
        add_ped_cycle("early");

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step(vecs[i].clr, vecs[i].walk, 1'b0);
                check($sformatf("%s[%0d]", vecs[i].name, c),
                      32'(observe()), 32'(vecs[i].exp));
            end
        end

        // Latch loop: WALK press discarded, FLASH press serviced later.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        use_latch = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!walk_on && n < 200) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("latch_reach_walk", 32'(walk_on), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("walk_press_cleared", 32'(latch_q), 32'd0);
        n = 0;
        while (!(car_red && !walk_on && count_out != 4'd0) && n < 100) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("latch_reach_flash", 32'(count_out), 32'd3);
        check("no_leak_into_flash", 32'(latch_q), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("flash_press_held", 32'(latch_q), 32'd1);
        n = 0;
        while (!car_green && n < 100) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("latch_reach_green", 32'(car_green), 32'd1);
        check("req_kept_at_green", 32'(latch_q), 32'd1);
        n = 0;
        while (!car_yellow && n < 100) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("green_min_before_second", n, 12);

        // Reset in the middle of WALK.
        use_latch = 1'b0;
        n = 0;
        while (!(walk_on && count_out == 4'd2) && n < 200) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        check("reach_walk_count2", 32'(count_out), 32'd2);
        step(1'b1, 1'b1, 1'b0);
        check("mid_walk_reset", 32'(observe()), 32'({LG, 1'b1, 4'd0}));
        n = 0;
        while (!car_yellow && n < 50) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        check("prescaler_restart", n, 12);

        // Random requests with lamp invariants checked every cycle.
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            check("one_car_lamp",
                  32'(car_green) + 32'(car_yellow) + 32'(car_red), 32'd1);
            check("walk_dontwalk_excl", 32'(walk_on & dontwalk_on), 32'd0);
            check("green_walk_excl", 32'(car_green & walk_on), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cwalk_ctrl.md
Name: cwalk_ctrl

Overview:
Crosswalk sequencing FSM, directly downstream of the pedestrian request latch (dff1).
- Consumes the latched walk request (the latch's q) and drives car lights, walk/don't-walk lamps and a countdown digit.
- Returns a clear strobe that feeds the latch's clr input, so each request is serviced exactly once.
- All timing is counted in ticks from an internal prescaler.

Parameters:
TICK_DIV, 50_000_000, clk cycles per tick (1 s at 50 MHz); must be >= 2
GREEN_MIN, 10, minimum car-green duration in ticks; 1..15
YELLOW_T, 3, car-yellow duration in ticks; 1..15
ALLRED_T, 1, all-red guard duration in ticks, used before and after the pedestrian phase; 1..15
WALK_T, 8, steady WALK duration in ticks; 1..15
FLASH_T, 5, flashing DON'T-WALK duration in ticks; 1..15

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous active-high reset
walk_req  input  1  latched pedestrian request (q of upstream dff1)
req_clr  output  1  clear strobe to the request latch
car_green  output  1  car green lamp
car_yellow  output  1  car yellow lamp
car_red  output  1  car red lamp
walk_on  output  1  pedestrian WALK lamp
dontwalk_on  output  1  pedestrian DON'T-WALK lamp
count_out  output  4  remaining pedestrian ticks, for the seven-segment display

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high. It is sampled only on the rising edge of clk and has priority over every other input.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick is an internal one-cycle pulse when the count equals TICK_DIV-1; the count then wraps to 0.
  - clr forces the count to 0.
- Timer: 4-bit down-counter.
  - Loaded with DUR-1 on state entry.
  - On tick: if timer==0 the FSM transitions, else the timer decrements.
  - Every timed state therefore lasts exactly DUR ticks.
- States and transitions (evaluated only on tick with timer==0):
  - GREEN -> YELLOW if walk_req==1. Otherwise stay in GREEN with timer held at 0, so a later request advances on its next tick.
  - YELLOW -> ALLRED1.
  - ALLRED1 -> WALK.
  - WALK -> FLASH.
  - FLASH -> ALLRED2.
  - ALLRED2 -> GREEN, with timer loaded to GREEN_MIN-1.
- Reset state: GREEN, timer=GREEN_MIN-1, prescaler=0, flash phase=0.
- Outputs are Moore, decoded from registered state; they change in the same cycle the state changes.
  - car_green=1 in GREEN only.
  - car_yellow=1 in YELLOW only.
  - car_red=1 in ALLRED1, WALK, FLASH, ALLRED2.
  - walk_on=1 in WALK only.
  - dontwalk_on=1 in GREEN, YELLOW, ALLRED1, ALLRED2. In FLASH it equals the flash phase bit.
  - Flash phase: set to 1 on FLASH entry, toggled on every tick within FLASH.
  - count_out = timer+1 in WALK and FLASH, 0 elsewhere.
- req_clr = clr OR (state==WALK).
  - Button presses during WALK are discarded, since the latch gives clr priority.
  - A press during FLASH or the all-red states stays latched and is serviced after the next GREEN_MIN.
- walk_req is sampled only on the tick that ends GREEN. Glitches between ticks have no effect.
- Reset mid-sequence: next cycle the outputs show GREEN with dontwalk_on=1, count_out=0, and the prescaler restarts. During reset, req_clr=1.
- Exactly one car lamp is lit in every state. walk_on and dontwalk_on are never both 1.

Decomposition:
- Package cwalk_pkg:
  - state encoding localparams: GREEN, YELLOW, ALLRED1, WALK, FLASH, ALLRED2 (3-bit)
  - timer width constant (4)
- Sub-module tick_gen (parameter TICK_DIV; ports clk, clr, tick) holds the prescaler. The FSM, timer and output decode stay in cwalk_ctrl.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, GREEN_MIN=3, YELLOW_T=2, ALLRED_T=1, WALK_T=4, FLASH_T=3.
1. Idle: clr high for 2 cycles, walk_req=0 for 40 cycles -> car_green=1, dontwalk_on=1, count_out=0 throughout; req_clr=1 only during reset.
2. Early request: walk_req=1 from cycle 1 -> GREEN held 12 cycles, then YELLOW 8, ALLRED1 4, WALK 16 (count_out 4,3,2,1 per tick, req_clr=1), FLASH 12 (dontwalk 1,0,1; count 3,2,1), ALLRED2 4, GREEN.
3. Late request: walk_req rises after 30 cycles in GREEN -> YELLOW entered on the next tick boundary, not earlier.
4. Latch loop: model dff1 upstream, pulse the button during WALK and again during FLASH -> the WALK press is cleared; the FLASH press persists, giving a second cycle after GREEN_MIN.
5. Reset mid-WALK: assert clr for 1 cycle at count_out=2 -> next cycle car_green=1, walk_on=0, count_out=0, prescaler at 0.
6. Lamp invariants: assertions over a random walk_req run of 2000 cycles -> exactly one car lamp lit; never walk_on&dontwalk_on; never car_green with walk_on.
